mem_wait_responder: RTL and testbench

//   Memory-side responder for the multi-cycle processor's memory port. Serves

---
 rtl/mem_wait_responder.sv | 138 +++++++++++++
 tb/tb_mem_wait_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the multi-cycle processor: one word array serving
// fetches, loads and stores after a fixed number of wait states.
module mem_wait_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              busy
);

  localparam int WORD_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r, nextState_s;
  logic [3:0]         cnt_r, nextCnt_s;
  logic [WORD_AW-1:0] capWord_r;
  logic [DATA_W-1:0]  capData_r;
  logic               capWrite_r, capIllegal_r;
  logic               capture_s, enterResp_s;
  logic [WORD_AW-1:0] respWord_s;
  logic [DATA_W-1:0]  respData_s;
  logic               respWrite_s, respIllegal_s;

  logic [DATA_W-1:0]  mem [DEPTH];

  function automatic logic isIllegal(input logic [ADDR_W-1:0] a,
                                     input logic rd, input logic wr);
    logic misaligned;
    logic outOfRange;
    misaligned = (a[1:0] != 2'b00);
    outOfRange = ((a >> (WORD_AW + 2)) != {ADDR_W{1'b0}});
    return misaligned | outOfRange | (rd & wr);
  endfunction

  // Next-state and counter logic for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    capture_s   = 1'b0;
    enterResp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_read | mem_write) begin
          capture_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            nextState_s = RESP;
            enterResp_s = 1'b1;
          end else begin
            nextState_s = WAIT;
            nextCnt_s   = 4'(WAIT_CYCLES);
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        nextCnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          nextState_s = RESP;
          enterResp_s = 1'b1;
        end else begin
          nextState_s = WAIT;
        end
      end
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so the live request is used.
  always_comb begin
    if (state_r == IDLE) begin
      respWord_s    = addr[WORD_AW+1:2];
      respData_s    = write_data;
      respWrite_s   = mem_write;
      respIllegal_s = isIllegal(addr, mem_read, mem_write);
    end else begin
      respWord_s    = capWord_r;
      respData_s    = capData_r;
      respWrite_s   = capWrite_r;
      respIllegal_s = capIllegal_r;
    end
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      capWord_r    <= '0;
      capData_r    <= '0;
      capWrite_r   <= 1'b0;
      capIllegal_r <= 1'b0;
      read_data    <= '0;
      mem_ready    <= 1'b0;
      mem_error    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
      if (capture_s) begin
        capWord_r    <= addr[WORD_AW+1:2];
        capData_r    <= write_data;
        capWrite_r   <= mem_write;
        capIllegal_r <= isIllegal(addr, mem_read, mem_write);
      end
      if (enterResp_s && !respWrite_s && !respIllegal_s) begin
        read_data <= mem[respWord_s];
      end
      busy      <= (nextState_s != IDLE);
      mem_ready <= (state_r == RESP);
      mem_error <= (state_r == RESP) && capIllegal_r;
    end
  end

  // Array write; guarded by rst so an access aborted by reset never lands.
  always_ff @(posedge clk) begin
    if (!rst && enterResp_s && respWrite_s && !respIllegal_s) begin
      mem[respWord_s] <= respData_s;
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: two instances (2 and 0 wait states) driven with
// directed and random accesses, checked against an array model of the memory.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead  [2];
  logic        memWrite [2];
  logic [31:0] addrA    [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        err      [2];
  logic        busyA    [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] modelMem   [2][1024];
  bit          modelKnown [2][1024];
  logic [31:0] expRd      [2];
  bit          expRdKnown [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    mem_wait_responder #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES((g == 0) ? 2 : 0)
    ) dut (
      .clk(clk), .rst(rst),
      .mem_read(memRead[g]), .mem_write(memWrite[g]),
      .addr(addrA[g]), .write_data(wdata[g]),
      .read_data(rdata[g]), .mem_ready(ready[g]),
      .mem_error(err[g]), .busy(busyA[g])
    );
  end

  function automatic int waitCyc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic checkEq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete access driven from a negedge; returns at the negedge where
  // mem_ready is seen, with the request still applied (caller drops or replaces it).
  task automatic access(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wd);
    int  w;
    int  cyc;
    int  busyCnt;
    bit  illegal;
    int  word;
    w       = waitCyc(d);
    cyc     = 0;
    busyCnt = 0;
    memRead[d]  = rd;
    memWrite[d] = wr;
    addrA[d]    = a;
    wdata[d]    = wd;
    illegal = (a[1:0] != 2'b00) || (a >= 32'h1000) || (rd && wr);
    word    = int'(a[11:2]);
    do begin
      @(negedge clk);
      cyc++;
      if (busyA[d]) busyCnt++;
      if (!ready[d]) begin
        addrA[d] = $urandom;
        wdata[d] = $urandom;
      end
    end while (!ready[d] && cyc < 40);
    checkEq("latency", cyc - 1, w + 1);
    checkEq("busyCycles", busyCnt, w + 1);
    checkEq("memError", err[d], illegal);
    if (!illegal && wr) begin
      modelMem[d][word]   = wd;
      modelKnown[d][word] = 1'b1;
    end
    if (!illegal && rd) begin
      expRd[d]      = modelMem[d][word];
      expRdKnown[d] = modelKnown[d][word];
    end
    if (expRdKnown[d]) checkEq("readData", rdata[d], expRd[d]);
  endtask

  task automatic idleCycles(int d, int n);
    memRead[d]  = 1'b0;
    memWrite[d] = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checkEq("readyIdle", ready[d], 1'b0);
      checkEq("busyIdle", busyA[d], 1'b0);
    end
  endtask

  task automatic randomAccess(int d);
    logic [31:0] a;
    int r;
    int k;
    r = $urandom_range(0, 99);
    if (r < 70)      a = 32'($urandom_range(0, 63)) << 2;
    else if (r < 75) a = 32'h0000_0FFC;
    else if (r < 85) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else if (r < 95) a = 32'h0000_1000 + (32'($urandom_range(0, 1000)) << 2);
    else             a = $urandom | 32'h8000_0000;
    k = $urandom_range(0, 9);
    if (k < 4)      access(d, 1'b1, 1'b0, a, $urandom);
    else if (k < 8) access(d, 1'b0, 1'b1, a, $urandom);
    else            access(d, 1'b1, 1'b1, a, $urandom);
    if ($urandom_range(0, 1) == 1) idleCycles(d, $urandom_range(1, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      memRead[d]    = 1'b0;
      memWrite[d]   = 1'b0;
      addrA[d]      = 32'h0;
      wdata[d]      = 32'h0;
      expRd[d]      = 32'h0;
      expRdKnown[d] = 1'b1;
      for (int i = 0; i < 1024; i++) begin
        modelMem[d][i]   = 32'h0;
        modelKnown[d][i] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkEq("rstReadData", rdata[d], 32'h0);
      checkEq("rstReady", ready[d], 1'b0);
      checkEq("rstError", err[d], 1'b0);
      checkEq("rstBusy", busyA[d], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Preload a region of each memory through the port itself.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) access(d, 1'b0, 1'b1, 32'(i) << 2, $urandom);
      access(d, 1'b0, 1'b1, 32'h0000_0FFC, $urandom);
      idleCycles(d, 1);
    end

    // Store then load with two wait states.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    idleCycles(0, 1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    checkEq("t1Read", rdata[0], 32'hDEAD_BEEF);
    idleCycles(0, 2);

    // Zero wait states, back-to-back reads with the request held.
    access(1, 1'b0, 1'b1, 32'h10, 32'hCAFE_0010);
    access(1, 1'b0, 1'b1, 32'h14, 32'hCAFE_0014);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b1, 1'b0, 32'h14, 32'h0);
    checkEq("t2Read14", rdata[1], 32'hCAFE_0014);
    idleCycles(1, 1);

    // Illegal requests on the two-wait-state instance.
    access(0, 1'b0, 1'b1, 32'h13, 32'h1111_1111);
    checkEq("t3Unchanged", rdata[0], 32'hDEAD_BEEF);
    idleCycles(0, 1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    checkEq("t3Read", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'h1000, 32'h0);
    checkEq("t4Keep", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'hFFC, 32'h0);
    checkEq("t4LegalErr", err[0], 1'b0);
    access(0, 1'b1, 1'b1, 32'h10, 32'h0);
    idleCycles(0, 1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    checkEq("t5Read", rdata[0], 32'hDEAD_BEEF);
    idleCycles(0, 1);

    // Reset in the middle of a write's wait states.
    access(0, 1'b0, 1'b1, 32'h20, 32'h0);
    idleCycles(0, 1);
    memWrite[0] = 1'b1;
    addrA[0]    = 32'h20;
    wdata[0]    = 32'h1234;
    @(negedge clk);
    checkEq("t6BusyBefore", busyA[0], 1'b1);
    rst = 1'b1;
    #1;
    checkEq("t6RstBusy", busyA[0], 1'b0);
    checkEq("t6RstReady", ready[0], 1'b0);
    checkEq("t6RstError", err[0], 1'b0);
    checkEq("t6RstData", rdata[0], 32'h0);
    memWrite[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      expRd[d]      = 32'h0;
      expRdKnown[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0);
    checkEq("t6Read", rdata[0], 32'h0);
    idleCycles(0, 1);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) randomAccess(d);
      idleCycles(d, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
